msft_dv_debug_apb_demux: RTL and testbench
==========================================

Name: msft_dv_debug_apb_demux

Overview:
- Parametrised APB requester-to-N-subordinate demultiplexer for the DV debug APB fabric. Generalises the fixed two-target debug mux to NUM_SUB targets with a parameter-defined address map.
- Adds a default-error responder, a per-transfer pready timeout that aborts hung subordinates, and sticky error/timeout status for the bench.
- Sits between the DPI-driven APB requester and the JTAG-debug, emulation and future debug subordinates.

Parameters:
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width (multiple of 8).
- NUM_SUB, 2, number of subordinates (1..16).
- SUB_BASE, {32'h0000_8000, 32'h0000_0000}, flat NUM_SUB*APB_ADDR_WIDTH vector; slice i is the base of sub i.
- SUB_MASK, {32'hFFFF_F000, 32'hFFFF_F000}, flat vector; sub i hits when (paddr & mask_i) == base_i.
- TIMEOUT_CYCLES, 64, access-phase wait cycles before abort; 0 disables the timeout.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- psel_apb_i, penable_apb_i, pwrite_apb_i  in  1 each  upstream APB controls.
- paddr_apb_i  in  APB_ADDR_WIDTH  upstream address.
- pwdata_apb_i  in  APB_DATA_WIDTH  upstream write data.
- pstrb_apb_i  in  APB_DATA_WIDTH/8  upstream write strobes.
- prdata_apb_o  out  APB_DATA_WIDTH  upstream read data.
- pready_apb_o, pslverr_apb_o  out  1 each  upstream completion and error.
- psel_sub_o  out  NUM_SUB  one-hot subordinate selects.
- penable_sub_o, pwrite_sub_o  out  1 each  broadcast controls.
- paddr_sub_o  out  APB_ADDR_WIDTH  broadcast address.
- pwdata_sub_o  out  APB_DATA_WIDTH  broadcast write data.
- pstrb_sub_o  out  APB_DATA_WIDTH/8  broadcast strobes.
- prdata_sub_i  in  NUM_SUB*APB_DATA_WIDTH  flat read data.
- pready_sub_i, pslverr_sub_i  in  NUM_SUB each  per-subordinate completion and error.
- clr_status_i  in  1  synchronous clear of the status outputs.
- timeout_sticky_o  out  1  set when any transfer has been aborted by timeout.
- timeout_idx_o  out  4  index of the subordinate in the last timeout.
- err_cnt_o  out  ERR_CNT_WIDTH  saturating count of pslverr_apb_o completions.

Behaviour:
- Reset: clock is clk_i; reset is asynchronous, active-low on rstn_i. FSM returns to IDLE, counters clear, all status outputs go to 0.
- After reset every output is 0. Broadcast outputs are combinational pass-through of upstream inputs.
- Decode (combinational): hit_i = (paddr & mask_i) == base_i. On overlapping windows, the lowest index wins. No hit selects DEF.
- psel_sub_o[i] = psel_apb_i & hit_i & (state != ABORT).
- FSM states: IDLE, ACCESS, ABORT.
- IDLE: on psel & ~penable (setup phase), register sel_idx (sub index or DEF) and go to ACCESS. Timeout counter clears.
- ACCESS with DEF selected: pready_apb_o=1, pslverr_apb_o=1, prdata=0 in the first access cycle (zero wait states). Return to IDLE.
- ACCESS with sub selected: pready/pslverr/prdata are muxed combinationally from sub sel_idx; non-selected inputs are ignored.
  - On pready_sub=1: transfer completes and the FSM returns to IDLE.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT_CYCLES (nonzero), go to ABORT.
- ABORT: lasts exactly one cycle. psel_sub_o all 0, pready_apb_o=1, pslverr_apb_o=1, prdata=0. timeout_sticky_o is set and timeout_idx_o=sel_idx. Return to IDLE.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted with no idle cycle.
- psel_apb_i dropping while in ACCESS (protocol violation) forces IDLE with no response; the counter clears.
- err_cnt_o increments on every cycle where pready_apb_o & pslverr_apb_o are both 1. It saturates at all-ones.
- clr_status_i clears the sticky flag, the index and the counter. If an error or timeout occurs in the same cycle, the new event wins: sticky=1 and cnt=1.
- Reset asserted mid-transfer: all outputs return to 0 immediately and the transfer is dropped.

Test Plan:
- Read 0x0000_0010, sub0 pready after 2 wait cycles with data 0xDEADBEEF: psel_sub_o=2'b01, prdata_apb_o=0xDEADBEEF, pslverr=0, err_cnt stays 0.
- Write 0x0000_8004, sub1 pslverr=1 with zero wait: psel_sub_o=2'b10, pslverr_apb_o=1 in the first access cycle, err_cnt_o=1.
- Read 0x0000_4000 (unmapped): psel_sub_o=0, pready=1, pslverr=1, prdata=0 in the first access cycle, err_cnt increments.
- TIMEOUT_CYCLES=4, sub1 never ready: abort response in access cycle 5, timeout_sticky_o=1, timeout_idx_o=1, psel_sub_o[1] drops in that cycle.
- Assert clr_status_i in the same cycle as a default-error completion: sticky=0, err_cnt_o=1. rstn_i low during ACCESS: all outputs 0 asynchronously, next transfer decodes normally.
- 300 default errors with ERR_CNT_WIDTH=8: err_cnt_o saturates at 255.

Source files
------------

// File: rtl/msft_dv_debug_apb_demux_if.sv
// APB requester/subordinate bundle for the DV debug demux.
// master = requester and subordinate models; slave = the demux itself.
interface msft_dv_debug_apb_demux_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int NUM_SUB        = 2
);
   logic                             psel_apb_i;
   logic                             penable_apb_i;
   logic                             pwrite_apb_i;
   logic [APB_ADDR_WIDTH-1:0]        paddr_apb_i;
   logic [APB_DATA_WIDTH-1:0]        pwdata_apb_i;
   logic [APB_DATA_WIDTH/8-1:0]      pstrb_apb_i;
   logic [APB_DATA_WIDTH-1:0]        prdata_apb_o;
   logic                             pready_apb_o;
   logic                             pslverr_apb_o;

   logic [NUM_SUB-1:0]               psel_sub_o;
   logic                             penable_sub_o;
   logic                             pwrite_sub_o;
   logic [APB_ADDR_WIDTH-1:0]        paddr_sub_o;
   logic [APB_DATA_WIDTH-1:0]        pwdata_sub_o;
   logic [APB_DATA_WIDTH/8-1:0]      pstrb_sub_o;
   logic [NUM_SUB*APB_DATA_WIDTH-1:0] prdata_sub_i;
   logic [NUM_SUB-1:0]               pready_sub_i;
   logic [NUM_SUB-1:0]               pslverr_sub_i;

   modport master (
      output psel_apb_i, penable_apb_i, pwrite_apb_i, paddr_apb_i, pwdata_apb_i, pstrb_apb_i,
      input  prdata_apb_o, pready_apb_o, pslverr_apb_o,
      input  psel_sub_o, penable_sub_o, pwrite_sub_o, paddr_sub_o, pwdata_sub_o, pstrb_sub_o,
      output prdata_sub_i, pready_sub_i, pslverr_sub_i
   );

   modport slave (
      input  psel_apb_i, penable_apb_i, pwrite_apb_i, paddr_apb_i, pwdata_apb_i, pstrb_apb_i,
      output prdata_apb_o, pready_apb_o, pslverr_apb_o,
      output psel_sub_o, penable_sub_o, pwrite_sub_o, paddr_sub_o, pwdata_sub_o, pstrb_sub_o,
      input  prdata_sub_i, pready_sub_i, pslverr_sub_i
   );
endinterface

// File: rtl/msft_dv_debug_apb_demux.sv
// APB 1-to-NUM_SUB demultiplexer with default-error responder, pready timeout
// abort and sticky error/timeout status.
module msft_dv_debug_apb_demux #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int NUM_SUB        = 2,
   parameter logic [NUM_SUB*APB_ADDR_WIDTH-1:0] SUB_BASE = {32'h0000_8000, 32'h0000_0000},
   parameter logic [NUM_SUB*APB_ADDR_WIDTH-1:0] SUB_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   msft_dv_debug_apb_demux_if.slave bus,
   input  logic                     clr_status_i,
   output logic                     timeout_sticky_o,
   output logic [3:0]               timeout_idx_o,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);
   localparam int AW    = APB_ADDR_WIDTH;
   localparam int DW    = APB_DATA_WIDTH;
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_e;

   state_e                   state_q, state_d;
   logic [3:0]               selIdx_q, selIdx_d;
   logic                     selDef_q, selDef_d;
   logic [CNT_W-1:0]         waitCnt_q, waitCnt_d;
   logic                     sticky_q, sticky_d;
   logic [3:0]               toutIdx_q, toutIdx_d;
   logic [ERR_CNT_WIDTH-1:0] errCnt_q, errCnt_d;

   logic                     hitAny;
   logic [3:0]               hitIdx;
   logic [NUM_SUB-1:0]       hitVec;
   logic                     subReady, subErr;
   logic [DW-1:0]            subRdata;
   logic                     pready, pslverr, timeoutEvt, errEvt;
   logic [DW-1:0]            prdata;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hitAny = 1'b0;
      hitIdx = '0;
      hitVec = '0;
      for (int i = NUM_SUB - 1; i >= 0; i--) begin
         if ((bus.paddr_apb_i & SUB_MASK[i*AW +: AW]) == SUB_BASE[i*AW +: AW]) begin
            hitAny = 1'b1;
            hitIdx = 4'(i);
         end
      end
      for (int i = 0; i < NUM_SUB; i++) begin
         hitVec[i] = hitAny && (hitIdx == 4'(i));
      end
   end

   always_comb begin
      subReady = 1'b0;
      subErr   = 1'b0;
      subRdata = '0;
      for (int i = 0; i < NUM_SUB; i++) begin
         if (selIdx_q == 4'(i)) begin
            subReady = bus.pready_sub_i[i];
            subErr   = bus.pslverr_sub_i[i];
            subRdata = bus.prdata_sub_i[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      selIdx_d   = selIdx_q;
      selDef_d   = selDef_q;
      waitCnt_d  = waitCnt_q;
      pready     = 1'b0;
      pslverr    = 1'b0;
      prdata     = '0;
      timeoutEvt = 1'b0;
      case (state_q)
         IDLE: begin
            waitCnt_d = '0;
            if (bus.psel_apb_i && !bus.penable_apb_i) begin
               selIdx_d = hitIdx;
               selDef_d = !hitAny;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!bus.psel_apb_i) begin
               state_d   = IDLE;
               waitCnt_d = '0;
            end else if (selDef_q) begin
               pready  = 1'b1;
               pslverr = 1'b1;
               state_d = IDLE;
            end else begin
               pready  = subReady;
               pslverr = subErr;
               prdata  = subRdata;
               if (subReady) begin
                  state_d   = IDLE;
                  waitCnt_d = '0;
               end else begin
                  waitCnt_d = waitCnt_q + CNT_W'(1);
                  if ((TIMEOUT_CYCLES != 0) && (waitCnt_d == CNT_W'(TIMEOUT_CYCLES))) begin
                     state_d    = ABORT;
                     timeoutEvt = 1'b1;
                  end
               end
            end
         end
         ABORT: begin
            pready    = 1'b1;
            pslverr   = 1'b1;
            state_d   = IDLE;
            waitCnt_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // A fresh error or timeout in the clearing cycle survives the clear.
   always_comb begin
      errEvt    = pready && pslverr;
      errCnt_d  = errCnt_q;
      sticky_d  = sticky_q;
      toutIdx_d = toutIdx_q;
      if (clr_status_i) begin
         errCnt_d = errEvt ? ERR_CNT_WIDTH'(1) : '0;
      end else if (errEvt && (errCnt_q != '1)) begin
         errCnt_d = errCnt_q + ERR_CNT_WIDTH'(1);
      end
      if (timeoutEvt) begin
         sticky_d  = 1'b1;
         toutIdx_d = selIdx_q;
      end else if (clr_status_i) begin
         sticky_d  = 1'b0;
         toutIdx_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         selIdx_q  <= '0;
         selDef_q  <= 1'b0;
         waitCnt_q <= '0;
         sticky_q  <= 1'b0;
         toutIdx_q <= '0;
         errCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         selIdx_q  <= selIdx_d;
         selDef_q  <= selDef_d;
         waitCnt_q <= waitCnt_d;
         sticky_q  <= sticky_d;
         toutIdx_q <= toutIdx_d;
         errCnt_q  <= errCnt_d;
      end
   end

   // Pass-through paths are gated by reset so a reset blanks every output at once.
   assign bus.psel_sub_o    = (rstn_i && bus.psel_apb_i && (state_q != ABORT)) ? hitVec : '0;
   assign bus.penable_sub_o = rstn_i && bus.penable_apb_i;
   assign bus.pwrite_sub_o  = rstn_i && bus.pwrite_apb_i;
   assign bus.paddr_sub_o   = rstn_i ? bus.paddr_apb_i  : '0;
   assign bus.pwdata_sub_o  = rstn_i ? bus.pwdata_apb_i : '0;
   assign bus.pstrb_sub_o   = rstn_i ? bus.pstrb_apb_i  : '0;

   assign bus.pready_apb_o  = pready;
   assign bus.pslverr_apb_o = pslverr;
   assign bus.prdata_apb_o  = prdata;

   assign timeout_sticky_o  = sticky_q;
   assign timeout_idx_o     = toutIdx_q;
   assign err_cnt_o         = errCnt_q;
endmodule

// File: tb/tb_msft_dv_debug_apb_demux.sv
// Directed bench for the APB demux: decode, wait states, default error,
// timeout abort, status clear, mid-transfer reset and counter saturation.
module tb_msft_dv_debug_apb_demux;
   logic       clk_i;
   logic       rstn_i;
   logic       clr_status_i;
   logic       timeout_sticky_o;
   logic [3:0] timeout_idx_o;
   logic [7:0] err_cnt_o;

   int checkCount = 0;
   int failCount  = 0;

   msft_dv_debug_apb_demux_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .NUM_SUB(2)) bus ();

   msft_dv_debug_apb_demux #(
      .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32),
      .NUM_SUB(2),
      .SUB_BASE({32'h0000_8000, 32'h0000_0000}),
      .SUB_MASK({32'hFFFF_F000, 32'hFFFF_F000}),
      .TIMEOUT_CYCLES(4),
      .ERR_CNT_WIDTH(8)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .bus(bus),
      .clr_status_i(clr_status_i),
      .timeout_sticky_o(timeout_sticky_o),
      .timeout_idx_o(timeout_idx_o),
      .err_cnt_o(err_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
      bus.psel_apb_i    = sel;
      bus.penable_apb_i = en;
      bus.pwrite_apb_i  = wr;
      bus.paddr_apb_i   = addr;
      bus.pwdata_apb_i  = wdata;
      bus.pstrb_apb_i   = strb;
   endtask

   task automatic setSub(input logic [1:0] ready, input logic [1:0] err, input logic [63:0] rdata);
      bus.pready_sub_i  = ready;
      bus.pslverr_sub_i = err;
      bus.prdata_sub_i  = rdata;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rstn_i       = 1'b1;
      clr_status_i = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      setSub(2'b00, 2'b00, 64'h0);
      #1 rstn_i = 1'b0;
      #2;
      checkOutput("rst_psel_sub", 64'(bus.psel_sub_o), 64'h0);
      checkOutput("rst_pready", 64'(bus.pready_apb_o), 64'h0);
      checkOutput("rst_pslverr", 64'(bus.pslverr_apb_o), 64'h0);
      checkOutput("rst_prdata", 64'(bus.prdata_apb_o), 64'h0);
      checkOutput("rst_sticky", 64'(timeout_sticky_o), 64'h0);
      checkOutput("rst_tidx", 64'(timeout_idx_o), 64'h0);
      checkOutput("rst_errcnt", 64'(err_cnt_o), 64'h0);
      #10 rstn_i = 1'b1;

      // Read sub0 with two wait states
      tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      #1 checkOutput("t1_setup_psel", 64'(bus.psel_sub_o), 64'h1);
      tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      #1 checkOutput("t1_wait1_pready", 64'(bus.pready_apb_o), 64'h0);
      tick();
      checkOutput("t1_wait2_pready", 64'(bus.pready_apb_o), 64'h0);
      tick(); setSub(2'b01, 2'b00, {32'h1111_2222, 32'hDEAD_BEEF});
      #1 checkOutput("t1_done_pready", 64'(bus.pready_apb_o), 64'h1);
      checkOutput("t1_done_prdata", 64'(bus.prdata_apb_o), 64'hDEAD_BEEF);
      checkOutput("t1_done_pslverr", 64'(bus.pslverr_apb_o), 64'h0);

      // Back-to-back write to sub1 with zero waits and slave error
      tick(); setSub(2'b00, 2'b00, 64'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_8004, 32'hA5A5_0001, 4'hF);
      #1 checkOutput("t2_setup_psel", 64'(bus.psel_sub_o), 64'h2);
      checkOutput("t2_paddr_sub", 64'(bus.paddr_sub_o), 64'h8004);
      checkOutput("t2_pwrite_sub", 64'(bus.pwrite_sub_o), 64'h1);
      checkOutput("t2_pwdata_sub", 64'(bus.pwdata_sub_o), 64'hA5A5_0001);
      checkOutput("t2_errcnt_before", 64'(err_cnt_o), 64'h0);
      tick(); applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_8004, 32'hA5A5_0001, 4'hF);
      setSub(2'b10, 2'b10, 64'h0);
      #1 checkOutput("t2_pready", 64'(bus.pready_apb_o), 64'h1);
      checkOutput("t2_pslverr", 64'(bus.pslverr_apb_o), 64'h1);
      tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); setSub(2'b00, 2'b00, 64'h0);
      #1 checkOutput("t2_errcnt", 64'(err_cnt_o), 64'h1);

      // Unmapped read answered by the default responder
      tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
      #1 checkOutput("t3_setup_psel", 64'(bus.psel_sub_o), 64'h0);
      tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
      setSub(2'b00, 2'b00, {64{1'b1}});
      #1 checkOutput("t3_pready", 64'(bus.pready_apb_o), 64'h1);
      checkOutput("t3_pslverr", 64'(bus.pslverr_apb_o), 64'h1);
      checkOutput("t3_prdata", 64'(bus.prdata_apb_o), 64'h0);
      tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); setSub(2'b00, 2'b00, 64'h0);
      #1 checkOutput("t3_errcnt", 64'(err_cnt_o), 64'h2);

      // Sub1 never ready: abort in access cycle 5
      tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_8000, 32'h0, 4'h0);
      setSub(2'b00, 2'b00, {64{1'b1}});
      #1 checkOutput("t4_setup_psel", 64'(bus.psel_sub_o), 64'h2);
      tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'h0);
      #1 checkOutput("t4_wait1_pready", 64'(bus.pready_apb_o), 64'h0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         checkOutput($sformatf("t4_wait%0d_pready", k), 64'(bus.pready_apb_o), 64'h0);
         checkOutput($sformatf("t4_wait%0d_psel", k), 64'(bus.psel_sub_o), 64'h2);
      end
      tick();
      checkOutput("t4_abort_psel", 64'(bus.psel_sub_o), 64'h0);
      checkOutput("t4_abort_pready", 64'(bus.pready_apb_o), 64'h1);
      checkOutput("t4_abort_pslverr", 64'(bus.pslverr_apb_o), 64'h1);
      checkOutput("t4_abort_prdata", 64'(bus.prdata_apb_o), 64'h0);
      checkOutput("t4_abort_sticky", 64'(timeout_sticky_o), 64'h1);
      checkOutput("t4_abort_tidx", 64'(timeout_idx_o), 64'h1);
      tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); setSub(2'b00, 2'b00, 64'h0);
      #1 checkOutput("t4_errcnt", 64'(err_cnt_o), 64'h3);
      checkOutput("t4_sticky_hold", 64'(timeout_sticky_o), 64'h1);

      // Clear coinciding with a default-error completion
      tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
      tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
      clr_status_i = 1'b1;
      #1 checkOutput("t5_pready", 64'(bus.pready_apb_o), 64'h1);
      tick(); clr_status_i = 1'b0; applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1 checkOutput("t5_sticky", 64'(timeout_sticky_o), 64'h0);
      checkOutput("t5_tidx", 64'(timeout_idx_o), 64'h0);
      checkOutput("t5_errcnt", 64'(err_cnt_o), 64'h1);

      // Reset during an access phase
      tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_8008, 32'h0, 4'h0);
      tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_8008, 32'h0, 4'h0);
      setSub(2'b10, 2'b00, {32'h1234_5678, 32'h0});
      #1 checkOutput("t6_pre_prdata", 64'(bus.prdata_apb_o), 64'h1234_5678);
      rstn_i = 1'b0;
      #1 checkOutput("t6_rst_pready", 64'(bus.pready_apb_o), 64'h0);
      checkOutput("t6_rst_prdata", 64'(bus.prdata_apb_o), 64'h0);
      checkOutput("t6_rst_psel", 64'(bus.psel_sub_o), 64'h0);
      checkOutput("t6_rst_paddr_sub", 64'(bus.paddr_sub_o), 64'h0);
      checkOutput("t6_rst_penable_sub", 64'(bus.penable_sub_o), 64'h0);
      checkOutput("t6_rst_errcnt", 64'(err_cnt_o), 64'h0);
      #1 rstn_i = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); setSub(2'b00, 2'b00, 64'h0);
      tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
      #1 checkOutput("t6_post_psel", 64'(bus.psel_sub_o), 64'h1);
      tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
      setSub(2'b01, 2'b00, {32'h0, 32'hCAFE_F00D});
      #1 checkOutput("t6_post_prdata", 64'(bus.prdata_apb_o), 64'hCAFE_F00D);
      checkOutput("t6_post_pready", 64'(bus.pready_apb_o), 64'h1);
      tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); setSub(2'b00, 2'b00, 64'h0);

      // 300 default errors saturate the 8-bit counter
      tick();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
         tick();
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
         tick();
         if (i == 253) checkOutput("t7_errcnt_254", 64'(err_cnt_o), 64'd254);
         if (i == 254) checkOutput("t7_errcnt_255", 64'(err_cnt_o), 64'd255);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1 checkOutput("t7_errcnt_sat", 64'(err_cnt_o), 64'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end
endmodule
